// File: rtl/display_scan.sv
// Four-digit multiplexed seven-segment scan driver with double-buffered
// digit/DP/flash data, inter-digit blanking, leading-zero suppression and edit flashing.
module display_scan #(
  parameter int DIGIT_CYCLES = 32,
  parameter int BLANK_CYCLES = 2,
  parameter int FLASH_FRAMES = 64
) (
  input  logic        clock,
  input  logic        nRst,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  flash_mask,
  input  logic        blank_lz,
  output logic [3:0]  bcd_out,
  output logic        DP,
  output logic [3:0]  nDigit,
  output logic        frame_done
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  logic [CW-1:0] c_q, c_d;
  logic [1:0]    d_q, d_d;
  logic [15:0]   shadow_bcd_q, shadow_bcd_d, act_bcd_q, act_bcd_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d, act_dp_q, act_dp_d;
  logic [3:0]    shadow_fl_q, shadow_fl_d, act_fl_q, act_fl_d;
  logic          pending_q, pending_d;
  logic          flash_phase_q, flash_phase_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          dp_q, dp_d;
  logic [3:0]    ndig_q, ndig_d;
  logic          fdone_q, fdone_d;

  logic          boundary;
  logic [3:0]    cur_digit;
  logic          suppress;

  assign bcd_out    = bcd_q;
  assign DP         = dp_q;
  assign nDigit     = ndig_q;
  assign frame_done = fdone_q;

  assign boundary  = (d_q == 2'd0) && (c_q == CW'(DIGIT_CYCLES - 1));
  assign cur_digit = act_bcd_q[{d_q, 2'b00} +: 4];

  // NOTE: every variable gets a default at the top so this block never infers a latch.
  always_comb begin
    c_d           = c_q;
    d_d           = d_q;
    shadow_bcd_d  = shadow_bcd_q;
    shadow_dp_d   = shadow_dp_q;
    shadow_fl_d   = shadow_fl_q;
    act_bcd_d     = act_bcd_q;
    act_dp_d      = act_dp_q;
    act_fl_d      = act_fl_q;
    pending_d     = pending_q | load;
    flash_phase_d = flash_phase_q;
    fcnt_d        = fcnt_q;
    ndig_d        = 4'hF;
    bcd_d         = 4'hF;
    dp_d          = 1'b0;
    fdone_d       = boundary;

    if (c_q == CW'(DIGIT_CYCLES - 1)) begin
      c_d = '0;
      d_d = d_q - 2'd1;
    end else begin
      c_d = c_q + CW'(1);
    end

    if (load) begin
      shadow_bcd_d = bcd_in;
      shadow_dp_d  = dp_mask;
      shadow_fl_d  = flash_mask;
    end

    // The active copy only changes between frames, so a frame never mixes two loads.
    if (boundary) begin
      if (pending_q) begin
        act_bcd_d = shadow_bcd_q;
        act_dp_d  = shadow_dp_q;
        act_fl_d  = shadow_fl_q;
      end
      pending_d = load;
      if (fcnt_q == FW'(FLASH_FRAMES - 1)) begin
        fcnt_d        = '0;
        flash_phase_d = ~flash_phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end

    // A digit is a leading zero when it and every digit to its left are 0 with no DP.
    suppress = blank_lz && (d_q != 2'd0);
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(d_q))
        suppress = suppress && (act_bcd_q[i*4 +: 4] == 4'd0) && !act_dp_q[i];
    end

    if ((c_q >= CW'(BLANK_CYCLES)) && !(flash_phase_q && act_fl_q[d_q])) begin
      ndig_d[d_q] = 1'b0;
      bcd_d       = suppress ? 4'hF : cur_digit;
      dp_d        = act_dp_q[d_q];
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!nRst) begin
      c_q           <= '0;
      d_q           <= 2'd3;
      shadow_bcd_q  <= '0;
      shadow_dp_q   <= '0;
      shadow_fl_q   <= '0;
      act_bcd_q     <= '0;
      act_dp_q      <= '0;
      act_fl_q      <= '0;
      pending_q     <= 1'b0;
      flash_phase_q <= 1'b0;
      fcnt_q        <= '0;
      bcd_q         <= 4'hF;
      dp_q          <= 1'b0;
      ndig_q        <= 4'hF;
      fdone_q       <= 1'b0;
    end else begin
      c_q           <= c_d;
      d_q           <= d_d;
      shadow_bcd_q  <= shadow_bcd_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_fl_q   <= shadow_fl_d;
      act_bcd_q     <= act_bcd_d;
      act_dp_q      <= act_dp_d;
      act_fl_q      <= act_fl_d;
      pending_q     <= pending_d;
      flash_phase_q <= flash_phase_d;
      fcnt_q        <= fcnt_d;
      bcd_q         <= bcd_d;
      dp_q          <= dp_d;
      ndig_q        <= ndig_d;
      fdone_q       <= fdone_d;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: directed scenarios plus random loads,
// compared every cycle against a frame/slot arithmetic reference model.
module tb_display_scan;

  localparam int DC = 32;
  localparam int BC = 2;
  localparam int FF = 64;
  localparam int F  = 4 * DC;

  logic        clock = 1'b0;
  logic        nRst;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_mask;
  logic [3:0]  flash_mask;
  logic        blank_lz;
  logic [3:0]  bcd_out;
  logic        DP;
  logic [3:0]  nDigit;
  logic        frame_done;

  display_scan #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .FLASH_FRAMES(FF)) dut (
    .clock(clock), .nRst(nRst), .load(load), .bcd_in(bcd_in), .dp_mask(dp_mask),
    .flash_mask(flash_mask), .blank_lz(blank_lz), .bcd_out(bcd_out), .DP(DP),
    .nDigit(nDigit), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          n;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [3:0]  fl;
  } load_t;

  load_t loads[$];
  int    checks = 0;
  int    errors = 0;
  int    n      = 0;   // scan cycles since the last reset release

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // Frame f shows the newest load sampled at least one cycle before the boundary ending frame f-1.
  function automatic void model(input int cyc, input logic lz, output logic [3:0] e_bcd,
                                output logic e_dp, output logic [3:0] e_nd, output logic e_fd);
    int pos, f, d, c, dig;
    logic ph, sup;
    load_t act;
    pos = cyc % F;
    f   = cyc / F;
    d   = 3 - pos / DC;
    c   = pos % DC;
    act = '{0, 16'h0, 4'h0, 4'h0};
    foreach (loads[i]) if (loads[i].n <= f * F - 2) act = loads[i];
    ph    = ((f / FF) % 2) == 1;
    e_fd  = (pos == F - 1);
    e_bcd = 4'hF;
    e_dp  = 1'b0;
    e_nd  = 4'hF;
    if (c >= BC && !(ph && act.fl[d])) begin
      e_nd[d] = 1'b0;
      dig = (act.bcd >> (4 * d)) & 15;
      sup = lz && (d >= 1);
      for (int j = d; j < 4; j++)
        if (((act.bcd >> (4 * j)) & 15) != 0 || act.dp[j]) sup = 1'b0;
      e_bcd = sup ? 4'hF : 4'(dig);
      e_dp  = act.dp[d];
    end
  endfunction

  task automatic step();
    logic [3:0] e_bcd, e_nd;
    logic       e_dp, e_fd;
    @(posedge clock);
    #1;
    if (!nRst) begin
      check("rst_bcd", 16'(bcd_out), 16'hF);
      check("rst_dp", 16'(DP), 16'h0);
      check("rst_ndigit", 16'(nDigit), 16'hF);
      check("rst_frame_done", 16'(frame_done), 16'h0);
      n = 0;
      loads.delete();
    end else begin
      if (load) loads.push_back('{n, bcd_in, dp_mask, flash_mask});
      model(n, blank_lz, e_bcd, e_dp, e_nd, e_fd);
      check("bcd_out", 16'(bcd_out), 16'(e_bcd));
      check("dp", 16'(DP), 16'(e_dp));
      check("ndigit", 16'(nDigit), 16'(e_nd));
      check("frame_done", 16'(frame_done), 16'(e_fd));
      n++;
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] dp, input logic [3:0] fl);
    load = 1'b1; bcd_in = b; dp_mask = dp; flash_mask = fl;
    step();
    load = 1'b0;
  endtask

  task automatic run_until_pos(input int target);
    int budget;
    budget = F + 1;
    while ((n % F) != target && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      errors++;
      $display("FAIL wait_pos: got %0d expected %0d", n % F, target);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRst = 1'b0; load = 1'b0; bcd_in = '0; dp_mask = '0; flash_mask = '0; blank_lz = 1'b0;
    run(2);
    nRst = 1'b1;

    do_load(16'h1234, 4'b0000, 4'b0000);
    run(3 * F);

    blank_lz = 1'b1;
    do_load(16'h0005, 4'b0000, 4'b0000);
    run(2 * F);
    blank_lz = 1'b0;
    run(F);

    blank_lz = 1'b1;
    do_load(16'h0005, 4'b0010, 4'b0000);
    run(2 * F);

    // Mid-frame load then a load exactly on the frame boundary.
    run_until_pos(F / 2);
    do_load(16'h9876, 4'b0001, 4'b0000);
    run_until_pos(F - 1);
    do_load(16'h4321, 4'b1000, 4'b0000);
    run(3 * F);

    blank_lz = 1'b0;
    do_load(16'h2100, 4'b0000, 4'b0100);
    run(130 * F);

    for (int i = 0; i < 30 * F; i++) begin
      if ($urandom_range(0, 96) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 63) == 0)
        do_load(16'($urandom), 4'($urandom), 4'($urandom));
      else
        step();
    end

    // Reset during digit 1's drive phase.
    blank_lz = 1'b0;
    run_until_pos(2 * DC + BC + 3);
    nRst = 1'b0;
    step();
    nRst = 1'b1;
    run(2 * F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
